// File: rtl/parity_frame_check_pkg.sv
// Shared types and helpers for the framed serial parity checker.
// Holds the parity state encoding and the frame bit-counter width helper.
package parity_frame_check_pkg;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } parity_state_e;

    // Width needed to count 0..frame_len-1; frame_len is at least 2, so this is never zero.
    function automatic int bit_cnt_width(input int frame_len);
        return $clog2(frame_len);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky all-ones flag.
// A clear takes priority over an increment arriving in the same cycle.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sat
);

    logic [CNT_WIDTH-1:0] count_reg, count_next;
    logic                 sat_reg, sat_next;

    always_comb begin
        count_next = count_reg;
        sat_next   = sat_reg;
        if (clr) begin
            count_next = '0;
            sat_next   = 1'b0;
        end else if (inc && (count_reg != {CNT_WIDTH{1'b1}})) begin
            count_next = count_reg + 1'b1;
            sat_next   = sat_reg | (count_next == {CNT_WIDTH{1'b1}});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            sat_reg   <= sat_next;
        end
    end

    assign count = count_reg;
    assign sat   = sat_reg;

endmodule

// File: rtl/parity_frame_check.sv
// Framed serial parity checker: groups accepted bits into FRAME_LEN-bit frames,
// issues a registered one-cycle verdict per frame and counts failed frames.
module parity_frame_check
    import parity_frame_check_pkg::*;
#(
    parameter int FRAME_LEN  = 8,
    parameter int ODD_PARITY = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seqValid,
    input  logic                 seqIn,
    input  logic                 resync,
    input  logic                 errClr,
    output logic                 detOut,
    output logic                 frameValid,
    output logic                 frameOk,
    output logic [CNT_WIDTH-1:0] errCount,
    output logic                 errSat
);

    localparam int            BW     = bit_cnt_width(FRAME_LEN);
    localparam logic [BW-1:0] LAST   = BW'(FRAME_LEN - 1);
    localparam parity_state_e TARGET = (ODD_PARITY != 0) ? ODD : EVEN;

    parity_state_e state_reg, state_next;
    parity_state_e base_state, toggled_state;
    logic [BW-1:0] bit_cnt_reg, bit_cnt_next, base_cnt;
    logic          frame_valid_reg, frame_valid_next;
    logic          frame_ok_reg, frame_ok_next;
    logic          frame_fail;

    always_comb begin
        // Resync takes effect before the bit of the same cycle is considered.
        base_state       = resync ? EVEN : state_reg;
        base_cnt         = resync ? '0 : bit_cnt_reg;
        toggled_state    = (seqValid && seqIn) ? ((base_state == EVEN) ? ODD : EVEN) : base_state;
        state_next       = base_state;
        bit_cnt_next     = base_cnt;
        frame_valid_next = 1'b0;
        frame_ok_next    = frame_ok_reg;
        frame_fail       = 1'b0;
        if (seqValid) begin
            if (base_cnt == LAST) begin
                frame_valid_next = 1'b1;
                frame_ok_next    = (toggled_state == TARGET);
                frame_fail       = (toggled_state != TARGET);
                state_next       = EVEN;
                bit_cnt_next     = '0;
            end else begin
                state_next   = toggled_state;
                bit_cnt_next = base_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= EVEN;
            bit_cnt_reg     <= '0;
            frame_valid_reg <= 1'b0;
            frame_ok_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bit_cnt_reg     <= bit_cnt_next;
            frame_valid_reg <= frame_valid_next;
            frame_ok_reg    <= frame_ok_next;
        end
    end

    // Counter updates on the same edge as the verdict, so it is current while frameValid is high.
    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (frame_fail),
        .clr  (errClr),
        .count(errCount),
        .sat  (errSat)
    );

    assign detOut     = (state_reg == EVEN);
    assign frameValid = frame_valid_reg;
    assign frameOk    = frame_ok_reg;

endmodule
